// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   VGA raster timing generator driven by a single system clock and a
//   one-cycle pixel strobe. Produces pixel coordinates, sync pulses, the
//   active-video flag and the gated pixel colour, all registered together
//   so they change on the same clock edge (zero skew). Scanning is started
//   by the run request and stops cleanly at a frame boundary. Losing the
//   pixel clock lock aborts the frame on the next clock edge.
//
// Build option:
//   VGA_TEST_PATTERN_EN - when defined, rgb_out shows eight vertical colour
//                         bars and pix_rgb is ignored. When undefined,
//                         rgb_out passes pix_rgb through during active video.
//
// Ports:
//   clk_in      in   system clock, the only clock
//   reset       in   asynchronous active-high reset
//   pix_en      in   one-clk_in pixel strobe
//   locked      in   pixel clock source valid
//   run         in   level request to scan frames
//   pix_rgb     in   pixel colour {R4,G4,B4} for the position being shown
//   hcount      out  current pixel column
//   vcount      out  current line
//   hsync       out  horizontal sync, active level SYNC_POL
//   vsync       out  vertical sync, active level SYNC_POL
//   de          out  active-video flag
//   frame_start out  one-cycle pulse when the raster lands on (0,0)
//   busy        out  scanning (not idle)
//   rgb_out     out  pixel colour, zero outside active video
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        locked,
  input  logic        run,
  input  logic [11:0] pix_rgb,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        busy,
  output logic [11:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopPend
  } state_t;

  state_t state;

  // Position after the next strobe and the decoded outputs for it.
  logic        h_wrap;
  logic        frame_wrap;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic [9:0]  tgt_h;
  logic [9:0]  tgt_v;
  logic        tgt_hsync;
  logic        tgt_vsync;
  logic        tgt_de;
  logic [11:0] tgt_colour;
  logic [11:0] tgt_rgb;
  logic        go_idle;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  // The pattern does not use the external colour input.
  logic unused_pix_rgb;
  assign unused_pix_rgb = ^pix_rgb;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [11:0] bar_colour(input logic [9:0] h);
    int unsigned bar;
    logic [11:0] c;
    bar = 32'(h) / BAR_W;
    if (bar > 7) begin
      bar = 7;
    end
    unique case (bar)
      0:       c = 12'hFFF;
      1:       c = 12'hFF0;
      2:       c = 12'h0FF;
      3:       c = 12'h0F0;
      4:       c = 12'hF0F;
      5:       c = 12'hF00;
      6:       c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction
`endif

  always_comb begin
    h_wrap     = (hcount == H_LAST);
    frame_wrap = h_wrap && (vcount == V_LAST);
    h_next     = h_wrap ? 10'd0 : hcount + 10'd1;
    if (!h_wrap) begin
      v_next = vcount;
    end else if (vcount == V_LAST) begin
      v_next = 10'd0;
    end else begin
      v_next = vcount + 10'd1;
    end

    // Leaving idle shows (0,0) itself rather than advancing past it.
    if (state == StIdle) begin
      tgt_h = 10'd0;
      tgt_v = 10'd0;
    end else begin
      tgt_h = h_next;
      tgt_v = v_next;
    end

    tgt_hsync = (tgt_h >= HS_START && tgt_h < HS_END) ? SYNC_ON : SYNC_OFF;
    tgt_vsync = (tgt_v >= VS_START && tgt_v < VS_END) ? SYNC_ON : SYNC_OFF;
    tgt_de    = (tgt_h < H_ACT_END) && (tgt_v < V_ACT_END);

`ifdef VGA_TEST_PATTERN_EN
    tgt_colour = bar_colour(tgt_h);
`else
    // Colour is captured on the same strobe that loads the position, so it
    // leaves the register together with hcount/vcount.
    tgt_colour = pix_rgb;
`endif
    tgt_rgb = tgt_de ? tgt_colour : 12'h000;

    // Lock loss aborts at once; a stop request ends at the frame wrap.
    go_idle = !locked ||
              ((state != StIdle) && pix_en && frame_wrap && !run);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      de          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      rgb_out     <= 12'h000;
    end else if (go_idle) begin
      state       <= StIdle;
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      de          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      rgb_out     <= 12'h000;
    end else begin
      // frame_start is a single-clock pulse even though the position holds.
      frame_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pix_en && run) begin
            state       <= StRun;
            busy        <= 1'b1;
            frame_start <= 1'b1;
            hcount      <= tgt_h;
            vcount      <= tgt_v;
            hsync       <= tgt_hsync;
            vsync       <= tgt_vsync;
            de          <= tgt_de;
            rgb_out     <= tgt_rgb;
          end
        end
        StRun, StStopPend: begin
          state <= run ? StRun : StStopPend;
          if (pix_en) begin
            frame_start <= frame_wrap;
            hcount      <= tgt_h;
            vcount      <= tgt_v;
            hsync       <= tgt_hsync;
            vsync       <= tgt_vsync;
            de          <= tgt_de;
            rgb_out     <= tgt_rgb;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// Self-checking bench for vga_timing_ctrl using a reduced raster
// (16+2+4+3 pixels by 8+1+2+2 lines) so several full frames fit in a short
// run. A behavioural model predicts every output each clock; predictions
// are queued when stimulus is applied and compared after the clock edge.
// Frame period, active pixels per frame, line period and hsync width are
// also measured from the DUT outputs and compared with the raster constants.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  localparam int unsigned HA = 16;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 4;
  localparam int unsigned HB = 3;
  localparam int unsigned VA = 8;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        locked;
  logic        run;
  logic [11:0] pix_rgb;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic        busy;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk_in(clk),
    .reset(reset),
    .pix_en(pix_en),
    .locked(locked),
    .run(run),
    .pix_rgb(pix_rgb),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .frame_start(frame_start),
    .busy(busy),
    .rgb_out(rgb_out)
  );

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        busy;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state.
  bit          m_act = 1'b0;
  int unsigned m_h   = 0;
  int unsigned m_v   = 0;
  bit          m_fs  = 1'b0;
  logic [11:0] m_rgb = 12'h000;

  // Measured raster statistics.
  bit          have_frame = 1'b0;
  int unsigned fs_gap     = 0;
  int unsigned de_cnt     = 0;
  bit          line_ok    = 1'b0;
  int unsigned hs_cnt     = 0;
  int unsigned line_gap   = 0;

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                            12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_colour(input int unsigned h);
`ifdef VGA_TEST_PATTERN_EN
    int unsigned idx;
    idx = h / (HA / 8);
    if (idx > 7) idx = 7;
    return bars[idx];
`else
    return pix_rgb;
`endif
  endfunction

  // Advance the model by one clock with the inputs about to be sampled.
  task automatic model_step(input logic en);
    exp_t e;
    bit   last;
    if (reset || !locked) begin
      m_act = 1'b0;
      m_h   = 0;
      m_v   = 0;
      m_fs  = 1'b0;
      m_rgb = 12'h000;
    end else begin
      m_fs = 1'b0;
      if (!m_act) begin
        if (en && run) begin
          m_act = 1'b1;
          m_fs  = 1'b1;
          m_rgb = model_colour(0);
        end
      end else if (en) begin
        last = (m_h == HT - 1) && (m_v == VT - 1);
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
        if (last && !run) m_act = 1'b0;
        else if (last) m_fs = 1'b1;
        m_rgb = model_colour(m_h);
      end
    end
    e.h    = m_h;
    e.v    = m_v;
    e.hs   = (m_h >= HA + HF && m_h < HA + HF + HS) ? 1'b0 : 1'b1;
    e.vs   = (m_v >= VA + VF && m_v < VA + VF + VS) ? 1'b0 : 1'b1;
    e.de   = m_act && (m_h < HA) && (m_v < VA);
    e.fs   = m_fs;
    e.busy = m_act;
    e.rgb  = e.de ? m_rgb : 12'h000;
    sb.push_back(e);
  endtask

  task automatic tick(input logic en);
    exp_t e;
    @(negedge clk);
    pix_en = en;
    model_step(en);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("hcount", 32'(hcount), e.h);
    check_eq("vcount", 32'(vcount), e.v);
    check_eq("hsync", 32'(hsync), 32'(e.hs));
    check_eq("vsync", 32'(vsync), 32'(e.vs));
    check_eq("de", 32'(de), 32'(e.de));
    check_eq("frame_start", 32'(frame_start), 32'(e.fs));
    check_eq("busy", 32'(busy), 32'(e.busy));
    check_eq("rgb_out", 32'(rgb_out), 32'(e.rgb));

    if (!busy) begin
      have_frame = 1'b0;
      line_ok    = 1'b0;
    end else if (en) begin
      if (frame_start) begin
        if (have_frame) begin
          check_eq("frame_period", fs_gap, HT * VT);
          check_eq("de_per_frame", de_cnt, HA * VA);
        end
        have_frame = 1'b1;
        fs_gap     = 0;
        de_cnt     = 0;
      end
      fs_gap++;
      if (de) de_cnt++;
      if (hcount == 10'd0) begin
        if (line_ok) begin
          check_eq("hsync_width", hs_cnt, HS);
          check_eq("line_period", line_gap, HT);
        end
        line_ok  = 1'b1;
        hs_cnt   = 0;
        line_gap = 0;
      end
      line_gap++;
      if (!hsync) hs_cnt++;
    end
  endtask

  // Pixel strobe on every fourth clock.
  task automatic strobe();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
  endtask

  task automatic run_until(input int unsigned h, input int unsigned v, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (!(m_h == h && m_v == v && m_act) && n < limit) begin
      strobe();
      n++;
    end
    check_eq("reach_h", 32'(hcount), h);
    check_eq("reach_v", 32'(vcount), v);
  endtask

  task automatic run_until_idle(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (m_act && n < limit) begin
      strobe();
      n++;
    end
    check_eq("stop_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_hcount"}, 32'(hcount), 32'd0);
    check_eq({tag, "_vcount"}, 32'(vcount), 32'd0);
    check_eq({tag, "_hsync"}, 32'(hsync), 32'd1);
    check_eq({tag, "_vsync"}, 32'(vsync), 32'd1);
    check_eq({tag, "_de"}, 32'(de), 32'd0);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rgb"}, 32'(rgb_out), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    pix_en  = 1'b0;
    locked  = 1'b0;
    run     = 1'b0;
    pix_rgb = 12'hA5C;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset  = 1'b0;
    locked = 1'b1;

    // Idle while run is low.
    repeat (3) strobe();

    // Start: first strobe shows (0,0) with frame_start.
    run = 1'b1;
    strobe();
    check_eq("entry_fs", 32'(frame_start), 32'd1);
    check_eq("entry_de", 32'(de), 32'd1);
    check_eq("entry_rgb", 32'(rgb_out), 32'(model_colour(0)));

    // Two full frames.
    repeat (2 * HT * VT) strobe();

    // Stop request mid-frame finishes the frame then idles.
    run_until(4, 3, HT * VT);
    run = 1'b0;
    run_until_idle(HT * VT + 5);
    check_eq("stop_h", 32'(hcount), 32'd0);
    check_eq("stop_v", 32'(vcount), 32'd0);
    repeat (2) strobe();

    // Stop then resume before the frame ends keeps scanning.
    run = 1'b1;
    strobe();
    run_until(4, 3, HT * VT);
    run = 1'b0;
    run_until(2, 5, HT * VT);
    run = 1'b1;
    run_until(HT - 1, VT - 1, HT * VT);
    strobe();
    check_eq("resume_fs", 32'(frame_start), 32'd1);
    check_eq("resume_busy", 32'(busy), 32'd1);

    // Strobe on every clock, different colour.
    pix_rgb = 12'h5A3;
    repeat (HT * VT + HT) tick(1'b1);

    // Lock loss aborts on the next clock regardless of the strobe.
    run_until(8, 4, HT * VT);
    locked = 1'b0;
    tick(1'b0);
    check_eq("unlock_de", 32'(de), 32'd0);
    check_eq("unlock_h", 32'(hcount), 32'd0);
    check_eq("unlock_busy", 32'(busy), 32'd0);
    repeat (3) tick(1'b1);
    locked = 1'b1;
    strobe();
    check_eq("relock_fs", 32'(frame_start), 32'd1);
    repeat (HT * 3) strobe();

    // Asynchronous reset inside the hsync pulse.
    run_until(HA + HF + 1, 2, HT * VT);
    check_eq("pre_reset_hsync", 32'(hsync), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick(1'b1);
    tick(1'b0);
    reset = 1'b0;
    strobe();
    check_eq("post_reset_fs", 32'(frame_start), 32'd1);
    repeat (HT * VT + 3) strobe();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit in case something blocks unexpectedly.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: front porch, sync and back porch widths in pixels (line total 800).
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical widths in lines (frame total 525).
REQ-004 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-005 SHALL have port clk_in, input, 1, system clock (100 MHz); the only clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port pix_en, input, 1, one-clk_in pixel strobe from the pixel clock divider.
REQ-008 SHALL have port locked, input, 1, pixel clock source valid.
REQ-009 SHALL have port run, input, 1, level request to scan frames.
REQ-010 SHALL have port pix_rgb, input, 12, pixel colour {R4,G4,B4} for the current hcount/vcount.
REQ-011 SHALL have outputs hcount (10) and vcount (10), current pixel position.
REQ-012 SHALL have outputs hsync (1), vsync (1), de (1, active-video flag), frame_start (1), busy (1) and rgb_out (12).

Function
REQ-013 SHALL implement states IDLE, RUN, STOP_PEND; all state and output registers SHALL update only on clk_in rising edges.
REQ-014 IDLE -> RUN SHALL occur on the first pix_en with run=1 and locked=1; counters SHALL stay at 0,0 on that strobe, so pixel (0,0) is the first one displayed.
REQ-015 In RUN/STOP_PEND, each pix_en SHALL advance hcount; hcount wraps from 799 to 0 and increments vcount; vcount wraps from 524 to 0.
REQ-016 Without pix_en, counters and all outputs SHALL hold their values.
REQ-017 RUN -> STOP_PEND SHALL occur when run=0; STOP_PEND -> RUN SHALL occur when run=1 before the frame ends.
REQ-018 STOP_PEND -> IDLE SHALL occur on the pix_en that wraps (799,524) -> (0,0); the counters SHALL be 0,0 in IDLE.
REQ-019 locked=0 in any state SHALL force IDLE on the next clk_in edge, clear counters and deassert de, regardless of pix_en.
REQ-020 hsync SHALL be active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-021 vsync SHALL be active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-022 de SHALL be 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE and state is not IDLE.
REQ-023 Active sync level SHALL equal SYNC_POL; the inactive level SHALL be ~SYNC_POL, including in IDLE.
REQ-024 hsync, vsync, de and rgb_out SHALL be registered and SHALL align with the hcount/vcount values presented in the same cycle (zero skew).
REQ-025 frame_start SHALL pulse for exactly one clk_in cycle when counters become 0,0 in RUN, including the IDLE -> RUN entry.
REQ-026 busy SHALL be 1 in RUN and STOP_PEND, and 0 in IDLE.
REQ-027 rgb_out SHALL be 0 whenever de=0.

Reset
REQ-028 reset SHALL asynchronously force IDLE, hcount=0, vcount=0, de=0, frame_start=0, busy=0, rgb_out=0, and hsync=vsync=~SYNC_POL.
REQ-029 Reset mid-frame SHALL abandon the frame; after release, operation SHALL resume only via REQ-014.

Configuration
REQ-030 With macro VGA_TEST_PATTERN_EN defined, rgb_out during de SHALL be eight vertical colour bars of H_ACTIVE/8 pixels each, in the order white, yellow, cyan, green, magenta, red, blue, black (channels 4'hF or 4'h0), and pix_rgb SHALL be ignored.
REQ-031 Without VGA_TEST_PATTERN_EN, rgb_out during de SHALL equal pix_rgb sampled with the same alignment as REQ-024.

Verification
REQ-032 reset released, locked=1, run=1, pix_en every 4th clk_in -> frame_start on the first strobe; hsync low for exactly 96 strobes starting at hcount=656; line period 800 strobes.
REQ-033 run full frame -> vsync low on vcount 490..491 only; de high for 640x480=307200 strobes per frame; next frame_start 420000 strobes after the previous one.
REQ-034 deassert run at (100,200) -> busy stays 1 until the (799,524) wrap, then IDLE with counters at 0,0; reasserting run at (5,300) instead keeps RUN with no gap.
REQ-035 drop locked at (320,240) -> next clk_in: IDLE, counters 0,0, de=0, syncs inactive; reassert locked -> restart at (0,0) with frame_start.
REQ-036 VGA_TEST_PATTERN_EN defined: rgb_out=12'hFFF at hcount 0..79, 12'hFF0 at 80..159, 12'h000 at 560..639, and 0 at hcount 640; undefined: pix_rgb=12'hA5C -> rgb_out=12'hA5C aligned with hcount during de, and 0 during blanking.
REQ-037 assert reset mid-line at hcount=700 -> all outputs at reset values immediately (asynchronously), without waiting for a clk_in edge.
